// File: rtl/shot_ctrl.sv
// Light-gun shot controller: synchronizes and debounces the trigger, then
// sequences a blackout frame and a target frame per shot, tracking ammo.
module shot_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int COOLDOWN_FRAMES = 30,
  parameter int AMMO            = 3
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_trigger,
  input  logic       i_reload,
  input  logic [9:0] i_row_count,
  input  logic [9:0] i_col_count,
  output logic       o_flash_black,
  output logic       o_flash_target,
  output logic       o_shot_fired,
  output logic [1:0] o_ammo,
  output logic       o_busy
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int FCW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [DBW-1:0] DB_LAST   = (DEBOUNCE_CYCLES > 0) ? DBW'(DEBOUNCE_CYCLES - 1) : '0;
  localparam logic [FCW-1:0] FC_LOAD   = FCW'(COOLDOWN_FRAMES);
  localparam logic [1:0]     AMMO_FULL = 2'(AMMO);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    BLACK,
    TARGET,
    COOLDOWN
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [1:0]     r_sync;
  logic           w_sync;
  logic           r_db_level;
  logic           r_db_prev;
  logic [DBW-1:0] r_db_cnt;
  logic [FCW-1:0] r_frame_cnt;
  logic [FCW-1:0] w_frame_cnt_next;
  logic [1:0]     r_ammo;
  logic [1:0]     w_ammo_next;
  logic           r_flash_black;
  logic           r_flash_target;
  logic           r_shot_fired;
  logic           r_busy;
  logic           w_press;
  logic           w_frame_tick;
  logic           w_accept;

  assign w_sync       = r_sync[1];
  assign w_press      = r_db_level & ~r_db_prev;
  assign w_frame_tick = (i_row_count == 10'd0) && (i_col_count == 10'd0);
  assign w_accept     = (r_state == IDLE) && w_press && (r_ammo != 2'd0);

  // The raw trigger is asynchronous, so nothing but this flop pair may look at it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_trigger};
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_db_level <= 1'b0;
      r_db_prev  <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_db_prev <= r_db_level;
      if (w_sync != r_db_level) begin
        if (r_db_cnt == DB_LAST) begin
          r_db_level <= w_sync;
          r_db_cnt   <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DBW'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_frame_cnt_next = r_frame_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next_state = ARM;
      end
      ARM: begin
        if (w_frame_tick) w_next_state = BLACK;
      end
      BLACK: begin
        if (w_frame_tick) w_next_state = TARGET;
      end
      TARGET: begin
        if (w_frame_tick) begin
          if (COOLDOWN_FRAMES == 0) begin
            w_next_state = IDLE;
          end else begin
            w_next_state     = COOLDOWN;
            w_frame_cnt_next = FC_LOAD;
          end
        end
      end
      COOLDOWN: begin
        if (w_frame_tick) begin
          if (r_frame_cnt <= FCW'(1)) begin
            w_next_state     = IDLE;
            w_frame_cnt_next = '0;
          end else begin
            w_frame_cnt_next = r_frame_cnt - FCW'(1);
          end
        end
      end
      default: begin
        w_next_state     = IDLE;
        w_frame_cnt_next = '0;
      end
    endcase
  end

  // Reload wins over the shot's decrement, except that a coincident shot still spends one round.
  always_comb begin
    w_ammo_next = r_ammo;
    if (i_reload) begin
      w_ammo_next = w_accept ? (AMMO_FULL - 2'd1) : AMMO_FULL;
    end else if (w_accept) begin
      w_ammo_next = r_ammo - 2'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_frame_cnt    <= '0;
      r_ammo         <= AMMO_FULL;
      r_flash_black  <= 1'b0;
      r_flash_target <= 1'b0;
      r_shot_fired   <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_frame_cnt    <= w_frame_cnt_next;
      r_ammo         <= w_ammo_next;
      r_flash_black  <= (w_next_state == BLACK);
      r_flash_target <= (w_next_state == TARGET);
      r_shot_fired   <= w_accept;
      r_busy         <= (w_next_state != IDLE);
    end
  end

  assign o_flash_black  = r_flash_black;
  assign o_flash_target = r_flash_target;
  assign o_shot_fired   = r_shot_fired;
  assign o_ammo         = r_ammo;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_shot_ctrl.sv
// Self-checking bench for shot_ctrl: a frame-counting reference model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_shot_ctrl;

  localparam int DB    = 4;
  localparam int CF    = 2;
  localparam int AM    = 3;
  localparam int ROWS  = 4;
  localparam int COLS  = 8;
  localparam int FRAME = ROWS * COLS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       trigger = 1'b0;
  logic       reload = 1'b0;
  logic [9:0] row = 10'd0;
  logic [9:0] col = 10'd0;
  logic       flashBlack;
  logic       flashTarget;
  logic       shotFired;
  logic [1:0] ammo;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int shotCount = 0;

  // Reference model: a shot starts a run of frame ticks; tick 1 opens the
  // blackout frame, tick 2 the target frame, tick 3+CF ends the sequence.
  bit trigQ[$] = '{1'b0, 1'b0};
  bit mLevel = 1'b0;
  int mRun = 0;
  bit mPressPending = 1'b0;
  bit mActive = 1'b0;
  int mTicks = 0;
  int mAmmo = AM;
  bit mShot = 1'b0;
  bit mTick;
  bit mAccept;
  bit mD;

  shot_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .COOLDOWN_FRAMES(CF),
    .AMMO(AM)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_trigger(trigger),
    .i_reload(reload),
    .i_row_count(row),
    .i_col_count(col),
    .o_flash_black(flashBlack),
    .o_flash_target(flashTarget),
    .o_shot_fired(shotFired),
    .o_ammo(ammo),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (col == 10'(COLS - 1)) begin
      col = 10'd0;
      row = (row == 10'(ROWS - 1)) ? 10'd0 : row + 10'd1;
    end else begin
      col = col + 10'd1;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      trigQ = '{1'b0, 1'b0};
      mLevel = 1'b0;
      mRun = 0;
      mPressPending = 1'b0;
      mActive = 1'b0;
      mTicks = 0;
      mAmmo = AM;
      mShot = 1'b0;
    end else begin
      mTick = (row == 10'd0) && (col == 10'd0);
      mAccept = mPressPending && !mActive && (mAmmo > 0);
      if (reload) mAmmo = mAccept ? AM - 1 : AM;
      else if (mAccept) mAmmo = mAmmo - 1;
      mShot = mAccept;
      if (mAccept) begin
        mActive = 1'b1;
        mTicks = 0;
      end else if (mActive && mTick) begin
        mTicks = mTicks + 1;
        if (mTicks == 3 + CF) mActive = 1'b0;
      end
      mD = trigQ.pop_front();
      trigQ.push_back(trigger);
      mPressPending = 1'b0;
      if (mD != mLevel) begin
        mRun = mRun + 1;
        if (mRun == DB) begin
          mLevel = mD;
          mRun = 0;
          mPressPending = mD;
        end
      end else begin
        mRun = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual != expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("model_shot_fired", int'(shotFired), int'(mShot));
      checkOutput("model_ammo", int'(ammo), mAmmo);
      checkOutput("model_busy", int'(busy), int'(mActive));
      checkOutput("model_flash_black", int'(flashBlack), int'(mActive && mTicks == 1));
      checkOutput("model_flash_target", int'(flashTarget), int'(mActive && mTicks == 2));
      if (shotFired) shotCount = shotCount + 1;
    end
  end

  function automatic bit sigSel(input int sel);
    case (sel)
      0:       return flashBlack;
      1:       return flashTarget;
      2:       return busy;
      default: return shotFired;
    endcase
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input bit trig, input bit rel, input int cycles);
    trigger = trig;
    reload = rel;
    waitCycles(cycles);
    reload = 1'b0;
  endtask

  task automatic pressTrigger();
    applyStimulus(1'b1, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 8);
  endtask

  task automatic waitFor(input string name, input int sel, input bit val, input int maxc,
                         output int waited);
    waited = 0;
    while (sigSel(sel) != val && waited < maxc) begin
      @(negedge clk);
      waited = waited + 1;
    end
    checkOutput({name, "_reached"}, int'(sigSel(sel)), int'(val));
  endtask

  task automatic measureHigh(input int sel, input int maxc, output int len);
    len = 0;
    while (sigSel(sel) && len < maxc) begin
      len = len + 1;
      @(negedge clk);
    end
  endtask

  task automatic shotFull(input string name);
    int w;
    trigger = 1'b1;
    waitFor({name, "_shot"}, 3, 1'b1, 40, w);
    trigger = 1'b0;
    waitFor({name, "_idle"}, 2, 1'b0, 8 * FRAME, w);
  endtask

  initial begin
    int w;
    int len;
    int base;

    waitCycles(3);
    checkOutput("reset_ammo", int'(ammo), 3);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_black", int'(flashBlack), 0);
    checkOutput("reset_target", int'(flashTarget), 0);
    checkOutput("reset_shot", int'(shotFired), 0);
    reset = 1'b0;
    waitCycles(5);

    $display("[TB] single shot");
    base = shotCount;
    trigger = 1'b1;
    waitFor("single_shot", 3, 1'b1, 40, w);
    checkOutput("single_shot_latency", w, 7);
    trigger = 1'b0;
    checkOutput("single_ammo", int'(ammo), 2);
    waitFor("single_black", 0, 1'b1, 2 * FRAME, w);
    measureHigh(0, 4 * FRAME, len);
    checkOutput("single_black_len", len, FRAME);
    measureHigh(1, 4 * FRAME, len);
    checkOutput("single_target_len", len, FRAME);
    measureHigh(2, 4 * FRAME, len);
    checkOutput("single_cooldown_len", len, 2 * FRAME);
    checkOutput("single_shot_count", shotCount - base, 1);

    $display("[TB] bounce");
    base = shotCount;
    for (int i = 0; i < 10; i++) applyStimulus(i % 2 == 0, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 20);
    checkOutput("bounce_shot_count", shotCount - base, 0);
    checkOutput("bounce_busy", int'(busy), 0);

    $display("[TB] busy drop");
    applyStimulus(1'b0, 1'b1, 1);
    base = shotCount;
    trigger = 1'b1;
    waitFor("drop_shot", 3, 1'b1, 40, w);
    trigger = 1'b0;
    waitFor("drop_black", 0, 1'b1, 2 * FRAME, w);
    pressTrigger();
    waitFor("drop_target", 1, 1'b1, 2 * FRAME, w);
    pressTrigger();
    waitFor("drop_cooldown", 1, 1'b0, 2 * FRAME, w);
    pressTrigger();
    waitFor("drop_idle", 2, 1'b0, 4 * FRAME, w);
    checkOutput("drop_shot_count", shotCount - base, 1);
    checkOutput("drop_ammo", int'(ammo), 2);

    $display("[TB] empty");
    applyStimulus(1'b0, 1'b1, 1);
    base = shotCount;
    for (int i = 0; i < 3; i++) shotFull("empty_seq");
    checkOutput("empty_ammo", int'(ammo), 0);
    pressTrigger();
    waitCycles(10);
    checkOutput("empty_shot_count", shotCount - base, 3);
    checkOutput("empty_ammo_held", int'(ammo), 0);
    checkOutput("empty_busy", int'(busy), 0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("empty_reload_ammo", int'(ammo), 3);
    shotFull("empty_refire");
    checkOutput("empty_refire_count", shotCount - base, 4);
    checkOutput("empty_refire_ammo", int'(ammo), 2);

    $display("[TB] reset mid-flash");
    trigger = 1'b1;
    waitFor("rst_shot", 3, 1'b1, 40, w);
    trigger = 1'b0;
    waitFor("rst_black", 0, 1'b1, 2 * FRAME, w);
    waitCycles(5);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_async_black", int'(flashBlack), 0);
    checkOutput("rst_async_busy", int'(busy), 0);
    checkOutput("rst_async_ammo", int'(ammo), 3);
    waitCycles(3);
    reset = 1'b0;
    base = shotCount;
    shotFull("rst_after");
    checkOutput("rst_after_count", shotCount - base, 1);
    checkOutput("rst_after_ammo", int'(ammo), 2);

    $display("[TB] coincident reload");
    shotFull("coin_prep");
    checkOutput("coin_prep_ammo", int'(ammo), 1);
    trigger = 1'b1;
    waitCycles(6);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    checkOutput("coin_shot", int'(shotFired), 1);
    checkOutput("coin_ammo", int'(ammo), 2);
    trigger = 1'b0;
    waitFor("coin_idle", 2, 1'b0, 8 * FRAME, w);

    $display("[TB] trigger held through reset");
    trigger = 1'b1;
    reset = 1'b1;
    waitCycles(3);
    reset = 1'b0;
    waitFor("held_shot", 3, 1'b1, 40, w);
    checkOutput("held_latency", w, 7);
    checkOutput("held_ammo", int'(ammo), 2);
    trigger = 1'b0;
    waitFor("held_idle", 2, 1'b0, 8 * FRAME, w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/shot_ctrl.md
SHOT_CTRL -- requirements
Module: shot_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, is the number of consecutive stable clk cycles (10 ms at 25 MHz) needed to accept a trigger level change.
REQ-002 Parameter COOLDOWN_FRAMES, default 30, is the number of frames after a shot during which new presses are ignored.
REQ-003 Parameter AMMO, default 3 (range 1..3), is the number of shots per round.
REQ-004 clk  input  1  pixel clock, 25 MHz; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 trigger  input  1  raw light-gun trigger, asynchronous to clk, high = pressed.
REQ-007 reload  input  1  synchronous single-cycle pulse that restores ammo.
REQ-008 row_count  input  10  current VGA line from the timing generator.
REQ-009 col_count  input  10  current VGA pixel from the timing generator.
REQ-010 flash_black  output  1  high for the whole blackout frame; the pattern generator draws all black.
REQ-011 flash_target  output  1  high for the whole target frame; the pattern generator draws the white hit box only.
REQ-012 shot_fired  output  1  single-cycle pulse per accepted shot.
REQ-013 ammo  output  2  shots remaining.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 trigger SHALL pass through a 2-flop synchronizer before any other use.
REQ-016 Debounce: the held level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any cycle of agreement clears the counter.
REQ-017 press SHALL be a one-cycle internal pulse on each 0->1 transition of the debounced level; a 1->0 transition produces nothing.
REQ-018 frame_tick SHALL be high in exactly the cycles where row_count==0 and col_count==0.
REQ-019 The FSM SHALL have the states IDLE, ARM, BLACK, TARGET and COOLDOWN.
REQ-020 In IDLE, press with ammo>0 SHALL move to ARM, pulse shot_fired on the next cycle, and decrement ammo on that same cycle.
REQ-021 In IDLE, press with ammo==0 SHALL be ignored: no shot_fired, no state change.
REQ-022 ARM SHALL move to BLACK on frame_tick, and BLACK SHALL move to TARGET on the next frame_tick.
REQ-023 From TARGET, the next frame_tick SHALL move to COOLDOWN with the frame counter loaded to COOLDOWN_FRAMES, or directly to IDLE if COOLDOWN_FRAMES==0.
REQ-024 COOLDOWN SHALL decrement the frame counter on each frame_tick and move to IDLE when it reaches 0.
REQ-025 flash_black SHALL be 1 exactly while in BLACK, flash_target exactly while in TARGET, and busy while not in IDLE; all outputs are registered.
REQ-026 Thus each flash output is high for exactly one full frame, from the cycle after the frame_tick that entered the state through the cycle of the frame_tick that leaves it.
REQ-027 A press outside IDLE SHALL be dropped, not queued.
REQ-028 reload SHALL set ammo to AMMO in any state without changing the FSM state.
REQ-029 If reload coincides with an accepted shot, ammo SHALL become AMMO-1.
REQ-030 ammo SHALL never wrap below 0.

Reset
REQ-031 While reset is high, the block SHALL hold: state IDLE, ammo=AMMO, flash_black=0, flash_target=0, shot_fired=0, busy=0, synchronizer flops=0, debounced level=0, and all counters=0.
REQ-032 Assertion of reset SHALL take effect immediately, including mid-flash, forcing both flash outputs low asynchronously.
REQ-033 If trigger is held high through reset release, it SHALL register as one press after synchronizer latency plus DEBOUNCE_CYCLES.

Verification (DEBOUNCE_CYCLES=4, COOLDOWN_FRAMES=2, AMMO=3; bench drives a short frame of 4 rows x 8 cols)
REQ-034 Single shot: clean trigger press in IDLE -> one shot_fired pulse, ammo 3->2, then flash_black high for exactly one frame, then flash_target high for exactly one frame, busy low again two frames later.
REQ-035 Bounce: trigger toggles every 2 cycles for 20 cycles, then stays low -> no shot_fired, state remains IDLE.
REQ-036 Busy drop: second press during BLACK, TARGET or COOLDOWN -> ignored; total of one shot_fired, ammo=2.
REQ-037 Empty: three full shot sequences then a fourth press -> ammo reads 0 and there is no fourth shot_fired; a reload pulse then sets ammo=3 and the next press fires.
REQ-038 Reset mid-flash: assert reset while flash_black=1 -> flash_black=0 asynchronously, ammo=3, busy=0; after release the block accepts a new press normally.
REQ-039 Coincident: reload on the same cycle as an accepted shot with ammo=1 -> ammo=2 and shot_fired pulses.
